mcs4_bus_master: RTL and testbench

Initiator side of the MCS-4 4-bit multiplexed bus. It generates the 8-phase instruction-cycle timing, asserts `sync`, and drives the 12-bit program counter over the address phases. It captures the instruction byte returned by the addressed i4001-class ROM and hands it to the CPU core. It sits between the i4004 core datapath and the shared `dbus`/`sync`/`cm_rom` wires that every ROM on the bus snoops.

---
 rtl/mcs4_bus_master_if.sv | 25 ++
 rtl/mcs4_bus_master.sv | 152 +++++++++++++++
 tb/tb_mcs4_bus_master.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mcs4_bus_master_if.sv
// Shared MCS-4 multiplexed bus wires: 4-bit data nibble, sync strobe and ROM command line.
// The master drives dbus_out/dbus_oe/sync/cm_rom; dbus_in is the wired-OR of all ROM drivers.
interface mcs4_bus_master_if;
    logic [3:0] dbus_in;
    logic [3:0] dbus_out;
    logic       dbus_oe;
    logic       sync;
    logic       cm_rom;

    modport master (
        input  dbus_in,
        output dbus_out,
        output dbus_oe,
        output sync,
        output cm_rom
    );

    modport slave (
        output dbus_in,
        input  dbus_out,
        input  dbus_oe,
        input  sync,
        input  cm_rom
    );
endinterface

// File: rtl/mcs4_bus_master.sv
// MCS-4 bus initiator: 8-phase instruction-cycle sequencer, PC address drive,
// instruction capture with two-word tracking, X2 I/O drive and deferred jumps.
package mcs4;
    typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;
endpackage

module mcs4_bus_master
    import mcs4::*;
#(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic                clk,
    input  logic                rst,
    mcs4_bus_master_if.master   bus,
    input  logic                pc_load,
    input  logic [11:0]         pc_load_addr,
    input  logic                io_req,
    input  logic [3:0]          io_data,
    output logic                instr_valid,
    output logic [3:0]          instr_opr,
    output logic [3:0]          instr_opa,
    output logic [11:0]         instr_pc,
    output logic                instr_second
);

    instr_cyc_t  phase_q, phase_d;
    logic [11:0] pc_q, pc_d;
    logic [3:0]  opr_q, opr_d;
    logic [3:0]  opa_q, opa_d;
    logic [11:0] ipc_q, ipc_d;
    logic        isec_q, isec_d;
    logic        sec_pend_q, sec_pend_d;
    logic        ld_pend_q, ld_pend_d;
    logic [11:0] ld_addr_q, ld_addr_d;
    logic        io_go_q, io_go_d;

    function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
        return (opr == 4'h1) || (opr == 4'h4) || (opr == 4'h5) || (opr == 4'h7) ||
               ((opr == 4'h2) && !opa[0]);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= X3;
            pc_q       <= RESET_PC;
            opr_q      <= '0;
            opa_q      <= '0;
            ipc_q      <= '0;
            isec_q     <= 1'b0;
            sec_pend_q <= 1'b0;
            ld_pend_q  <= 1'b0;
            ld_addr_q  <= '0;
            io_go_q    <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            pc_q       <= pc_d;
            opr_q      <= opr_d;
            opa_q      <= opa_d;
            ipc_q      <= ipc_d;
            isec_q     <= isec_d;
            sec_pend_q <= sec_pend_d;
            ld_pend_q  <= ld_pend_d;
            ld_addr_q  <= ld_addr_d;
            io_go_q    <= io_go_d;
        end
    end

    always_comb begin
        phase_d      = phase_q;
        pc_d         = pc_q;
        opr_d        = opr_q;
        opa_d        = opa_q;
        ipc_d        = ipc_q;
        isec_d       = isec_q;
        sec_pend_d   = sec_pend_q;
        ld_pend_d    = ld_pend_q;
        ld_addr_d    = ld_addr_q;
        io_go_d      = io_go_q;
        bus.dbus_oe  = 1'b0;
        bus.dbus_out = '0;
        bus.cm_rom   = 1'b0;

        if (pc_load) begin
            ld_pend_d = 1'b1;
            ld_addr_d = pc_load_addr;
        end

        case (phase_q)
            A1: begin
                phase_d      = A2;
                bus.dbus_oe  = 1'b1;
                bus.dbus_out = pc_q[3:0];
            end
            A2: begin
                phase_d      = A3;
                bus.dbus_oe  = 1'b1;
                bus.dbus_out = pc_q[7:4];
            end
            A3: begin
                phase_d      = M1;
                bus.dbus_oe  = 1'b1;
                bus.dbus_out = pc_q[11:8];
                bus.cm_rom   = 1'b1;
            end
            M1: begin
                phase_d = M2;
                opr_d   = bus.dbus_in;
            end
            M2: begin
                phase_d = X1;
                opa_d   = bus.dbus_in;
                ipc_d   = pc_q;
                pc_d    = pc_q + 12'd1;
                isec_d  = sec_pend_q;
                // a second word only clears the flag; it is never decoded itself
                sec_pend_d = sec_pend_q ? 1'b0 : is_two_word(opr_q, bus.dbus_in);
            end
            X1: begin
                phase_d = X2;
                io_go_d = io_req && (opr_q == 4'hE) && !isec_q;
            end
            X2: begin
                phase_d = X3;
                io_go_d = 1'b0;
                if (io_go_q) begin
                    bus.dbus_oe  = 1'b1;
                    bus.dbus_out = io_data;
                    bus.cm_rom   = 1'b1;
                end
            end
            X3: begin
                phase_d = A1;
                // a pulse in X3 itself bypasses the pending register
                if (pc_load || ld_pend_q) begin
                    pc_d       = pc_load ? pc_load_addr : ld_addr_q;
                    ld_pend_d  = 1'b0;
                    sec_pend_d = 1'b0;
                end
            end
            default: phase_d = X3;
        endcase

        bus.sync    = (phase_q == X3);
        instr_valid = (phase_q == X1);
    end

    assign instr_opr    = opr_q;
    assign instr_opa    = opa_q;
    assign instr_pc     = ipc_q;
    assign instr_second = isec_q;

endmodule

// File: tb/tb_mcs4_bus_master.sv
// Scoreboard bench for mcs4_bus_master: a snooping ROM model serves fetches, stimulus
// queues expected addresses/words, and a negedge monitor checks every bus phase.
module tb_mcs4_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_load = 1'b0;
    logic [11:0] pc_load_addr = '0;
    logic        io_req = 1'b0;
    logic [3:0]  io_data = '0;
    logic        instr_valid;
    logic [3:0]  instr_opr;
    logic [3:0]  instr_opa;
    logic [11:0] instr_pc;
    logic        instr_second;

    always #5 clk = ~clk;

    mcs4_bus_master_if bus ();

    mcs4_bus_master #(.RESET_PC(12'h000)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.master),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .io_req       (io_req),
        .io_data      (io_data),
        .instr_valid  (instr_valid),
        .instr_opr    (instr_opr),
        .instr_opa    (instr_opa),
        .instr_pc     (instr_pc),
        .instr_second (instr_second)
    );

    // ROM model: follows sync to know the phase, latches the address nibbles, answers in M1/M2
    logic [7:0]  rom [4096];
    int          ph;
    int          cyc;
    logic [3:0]  a_lo, a_mid, a_hi;
    logic [7:0]  rom_word;

    always_ff @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst)           ph <= 7;
        else if (bus.sync) ph <= 0;
        else if (ph < 7)   ph <= ph + 1;
        if (ph == 0) a_lo  <= bus.dbus_out;
        if (ph == 1) a_mid <= bus.dbus_out;
        if (ph == 2) a_hi  <= bus.dbus_out;
    end

    assign rom_word    = rom[{a_hi, a_mid, a_lo}];
    assign bus.dbus_in = (ph == 3) ? rom_word[7:4] : (ph == 4) ? rom_word[3:0] : 4'h0;

    int          tests = 0;
    int          fails = 0;
    logic [11:0] exp_addr_q [$];
    logic [20:0] exp_instr_q [$];
    logic        exp_io = 1'b0;
    logic [3:0]  exp_io_d = '0;
    int          last_v = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ph(input int p);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ph != p && n < 20);
        if (ph != p) check("phase_wait_timeout", ph, p);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) last_v = -1;
            check("sync", bus.sync, ph == 7);
            case (ph)
                0, 1: check("addr_phase_oe_cm", {bus.dbus_oe, bus.cm_rom}, 2'b10);
                2: begin
                    check("a3_oe_cm", {bus.dbus_oe, bus.cm_rom}, 2'b11);
                    if (exp_addr_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_fetch: got addr 0x%0h, expected none",
                                 {bus.dbus_out, a_mid, a_lo});
                    end else begin
                        check("fetch_addr", {bus.dbus_out, a_mid, a_lo}, exp_addr_q.pop_front());
                    end
                end
                6: check("x2_bus", {bus.dbus_oe, bus.cm_rom, bus.dbus_out},
                         exp_io ? {2'b11, exp_io_d} : 6'h00);
                default: check("idle_bus", {bus.dbus_oe, bus.cm_rom, bus.dbus_out}, 6'h00);
            endcase
            check("instr_valid_x1", instr_valid, ph == 5);
            if (instr_valid) begin
                if (last_v >= 0) check("valid_period", cyc - last_v, 8);
                last_v = cyc;
                if (exp_instr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_instr: got pc 0x%0h, expected none", instr_pc);
                end else begin
                    check("instr_word", {instr_opr, instr_opa, instr_pc, instr_second},
                          exp_instr_q.pop_front());
                end
            end
        end
    endtask

    // called in X3; ld_ph 7 = pulse in this X3, 3 = pulse in M1, other = none
    // io 1 = request with drive expected, 2 = request that must be ignored
    task automatic run_fetch(input logic [11:0] pc, input logic [3:0] opr, input logic [3:0] opa,
                             input logic sec, input int ld_ph, input logic [11:0] ld_addr,
                             input int io);
        exp_addr_q.push_back(pc);
        exp_instr_q.push_back({opr, opa, pc, sec});
        if (ld_ph == 7) begin
            pc_load = 1'b1;
            pc_load_addr = ld_addr;
            wait_ph(0);
            pc_load = 1'b0;
            pc_load_addr = '0;
        end else if (ld_ph == 3) begin
            wait_ph(3);
            pc_load = 1'b1;
            pc_load_addr = ld_addr;
            wait_ph(4);
            pc_load = 1'b0;
        end
        if (io != 0) begin
            wait_ph(5);
            io_req = 1'b1;
            io_data = 4'h9;
            exp_io = (io == 1);
            exp_io_d = 4'h9;
            wait_ph(6);
            io_req = 1'b0;
        end
        wait_ph(7);
        io_data = '0;
        exp_io = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        check("rst_sync", bus.sync, 1'b1);
        check("rst_bus", {bus.dbus_oe, bus.dbus_out, bus.cm_rom, instr_valid}, 7'h00);
        check("rst_instr", {instr_opr, instr_opa, instr_pc, instr_second}, 21'h0);
        rst = 1'b0;
        #1;
        check("release_sync", bus.sync, 1'b1);
    endtask

    task automatic stimulus();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[0] = 8'hA3;
        do_reset(3);
        run_fetch(12'h000, 4'hA, 4'h3, 1'b0, 0, 12'h000, 0);

        rst = 1'b1;
        rom[12'h000] = 8'h11;
        rom[12'h001] = 8'h22;
        rom[12'h002] = 8'hD0;
        rom[12'h003] = 8'hD1;
        rom[12'h1F0] = 8'hE2;
        rom[12'h1F1] = 8'hE2;
        rom[12'h1F2] = 8'h70;
        rom[12'hFFF] = 8'h40;
        do_reset(2);
        run_fetch(12'h000, 4'h1, 4'h1, 1'b0, 0, 12'h000, 0);
        run_fetch(12'h001, 4'h2, 4'h2, 1'b1, 0, 12'h000, 0);
        run_fetch(12'h002, 4'hD, 4'h0, 1'b0, 0, 12'h000, 0);
        run_fetch(12'h003, 4'hD, 4'h1, 1'b0, 3, 12'h1F0, 0);
        run_fetch(12'h1F0, 4'hE, 4'h2, 1'b0, 0, 12'h000, 1);
        run_fetch(12'h1F1, 4'hE, 4'h2, 1'b0, 0, 12'h000, 0);
        run_fetch(12'hFFF, 4'h4, 4'h0, 1'b0, 7, 12'hFFF, 0);
        run_fetch(12'h000, 4'h1, 4'h1, 1'b1, 0, 12'h000, 0);
        run_fetch(12'h001, 4'h2, 4'h2, 1'b0, 3, 12'h1F1, 0);
        run_fetch(12'h1F1, 4'hE, 4'h2, 1'b0, 0, 12'h000, 1);
        run_fetch(12'h1F2, 4'h7, 4'h0, 1'b0, 0, 12'h000, 0);

        // abort the 0x1F3 fetch in M1; its pending jump and the two-word flag must vanish
        exp_addr_q.push_back(12'h1F3);
        wait_ph(0);
        pc_load = 1'b1;
        pc_load_addr = 12'h123;
        wait_ph(1);
        pc_load = 1'b0;
        wait_ph(3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_sync", bus.sync, 1'b1);
        check("abort_instr_cleared", {instr_opr, instr_pc}, 16'h0);
        run_fetch(12'h000, 4'h1, 4'h1, 1'b0, 0, 12'h000, 0);
        run_fetch(12'h001, 4'h2, 4'h2, 1'b1, 0, 12'h000, 2);

        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("addr_queue_drained", exp_addr_q.size(), 0);
        check("instr_queue_drained", exp_instr_q.size(), 0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            begin
                #100000;
                $display("FAIL watchdog: got no completion, expected finish before 100us");
                $fatal(1, "watchdog");
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
